// File: rtl/uvmt_cv32e40x_base_pkg.sv
// Shared types and helpers for the RVFI/OBI data tracker.
// Holds the FIFO entry layout and the byte-mask group counter.
package uvmt_cv32e40x_base_pkg;

  localparam int unsigned MASK_W_MAX = 64;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic        done;
    logic        err;
  } obi_entry_t;

  // One OBI transaction per nonzero 4-bit group of the RVFI byte mask
  function automatic int unsigned count_nz_nibbles(input logic [MASK_W_MAX-1:0] mask);
    int unsigned cnt;
    cnt = 0;
    for (int unsigned i = 0; i < MASK_W_MAX / 4; i++) begin
      if (mask[4*i +: 4] != 4'h0) cnt++;
    end
    return cnt;
  endfunction

endpackage

// File: rtl/uvmt_cv32e40x_rvfi_obi_fifo.sv
// In-order OBI transaction FIFO: push on grant, mark done on response,
// pop a variable number of completed entries per cycle.
module uvmt_cv32e40x_rvfi_obi_fifo
  import uvmt_cv32e40x_base_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned NMEM  = 13,
  localparam int unsigned PW   = $clog2(DEPTH) + 1,
  localparam int unsigned CW   = $clog2(NMEM + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          i_push,
  input  logic [31:0]   i_push_addr,
  input  logic          i_push_we,
  input  logic          i_cmpl,
  input  logic          i_cmpl_err,
  input  logic [CW-1:0] i_pop_cnt,
  output logic          o_cmpl_ok,
  output logic [PW-1:0] o_done_cnt,
  output logic [31:0]   o_head_addr,
  output logic          o_pop_err,
  output logic          o_overflow,
  output logic          o_cmpl_underflow
);

  localparam int unsigned IW = PW - 1;

  obi_entry_t    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_dn_ptr;

  logic w_full;
  logic w_push_ok;
  logic w_cmpl_ok;
  logic w_pop_err;

  assign w_full    = (r_wr_ptr[IW-1:0] == r_rd_ptr[IW-1:0]) && (r_wr_ptr[IW] != r_rd_ptr[IW]);
  // A full FIFO still accepts a push when entries leave in the same cycle
  assign w_push_ok = i_push && (!w_full || (i_pop_cnt != '0));
  assign w_cmpl_ok = i_cmpl && (r_dn_ptr != r_wr_ptr);

  assign o_cmpl_ok        = w_cmpl_ok;
  assign o_done_cnt       = r_dn_ptr - r_rd_ptr;
  assign o_head_addr      = r_mem[r_rd_ptr[IW-1:0]].addr;
  assign o_overflow       = i_push && !w_push_ok;
  assign o_cmpl_underflow = i_cmpl && !w_cmpl_ok;
  assign o_pop_err        = w_pop_err;

  // The entry completing this cycle takes its error bit straight from the bus
  always_comb begin
    logic [PW-1:0] idx;
    w_pop_err = 1'b0;
    idx       = '0;
    for (int unsigned i = 0; i < NMEM; i++) begin
      idx = r_rd_ptr + PW'(i);
      if (i < 32'(i_pop_cnt)) begin
        if (w_cmpl_ok && (idx == r_dn_ptr)) w_pop_err = w_pop_err | i_cmpl_err;
        else                                w_pop_err = w_pop_err | r_mem[idx[IW-1:0]].err;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_dn_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_cmpl_ok) r_dn_ptr <= r_dn_ptr + 1'b1;
      r_rd_ptr <= r_rd_ptr + PW'(i_pop_cnt);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr[IW-1:0]] <= '{addr: i_push_addr, we: i_push_we, done: 1'b0, err: 1'b0};
    end
    if (w_cmpl_ok) begin
      r_mem[r_dn_ptr[IW-1:0]].done <= 1'b1;
      r_mem[r_dn_ptr[IW-1:0]].err  <= i_cmpl_err;
    end
  end

endmodule

// File: rtl/uvmt_cv32e40x_rvfi_obi_data_tracker.sv
// Pairs each RVFI retirement with the data OBI transactions it caused and
// reports count, split flag, first address, error and bookkeeping faults.
module uvmt_cv32e40x_rvfi_obi_data_tracker
  import uvmt_cv32e40x_base_pkg::*;
#(
  parameter int unsigned NMEM  = 13,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       data_req,
  input  logic                       data_gnt,
  input  logic [31:0]                data_addr,
  input  logic                       data_we,
  input  logic                       data_rvalid,
  input  logic                       data_err,
  input  logic                       rvfi_valid,
  input  logic                       rvfi_trap_exception,
  input  logic [NMEM*4-1:0]          rvfi_mem_rmask,
  input  logic [NMEM*4-1:0]          rvfi_mem_wmask,
  output logic                       trk_valid,
  output logic                       is_split_datatrans,
  output logic [$clog2(NMEM+1)-1:0]  nr_obi_trans,
  output logic [31:0]                first_addr,
  output logic                       any_err,
  output logic                       err_overflow,
  output logic                       err_underflow
);

  localparam int unsigned CW = $clog2(NMEM + 1);
  localparam int unsigned PW = $clog2(DEPTH) + 1;

  logic [PW-1:0] w_done_cnt;
  logic          w_cmpl_ok;
  logic [31:0]   w_head_addr;
  logic          w_pop_err;
  logic          w_ovf;
  logic          w_cmpl_unf;
  logic [CW-1:0] w_pop_cnt;
  logic          w_ret_unf;
  int unsigned   w_need;
  int unsigned   w_avail;
  int unsigned   w_take;

  logic          r_trk_valid;
  logic          r_split;
  logic [CW-1:0] r_nr;
  logic [31:0]   r_first_addr;
  logic          r_any_err;
  logic          r_err_overflow;
  logic          r_err_underflow;

  uvmt_cv32e40x_rvfi_obi_fifo #(
    .DEPTH (DEPTH),
    .NMEM  (NMEM)
  ) u_fifo (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .i_push           (data_req && data_gnt),
    .i_push_addr      (data_addr),
    .i_push_we        (data_we),
    .i_cmpl           (data_rvalid),
    .i_cmpl_err       (data_err),
    .i_pop_cnt        (w_pop_cnt),
    .o_cmpl_ok        (w_cmpl_ok),
    .o_done_cnt       (w_done_cnt),
    .o_head_addr      (w_head_addr),
    .o_pop_err        (w_pop_err),
    .o_overflow       (w_ovf),
    .o_cmpl_underflow (w_cmpl_unf)
  );

  // Entries completing this cycle are already eligible for consumption
  always_comb begin
    w_need    = count_nz_nibbles(MASK_W_MAX'(rvfi_mem_rmask | rvfi_mem_wmask));
    w_avail   = 32'(w_done_cnt) + 32'(w_cmpl_ok);
    w_take    = 0;
    w_ret_unf = 1'b0;
    if (rvfi_valid) begin
      w_take    = (w_need < w_avail) ? w_need : w_avail;
      w_ret_unf = !rvfi_trap_exception && (w_need > w_avail);
    end
    w_pop_cnt = CW'(w_take);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_trk_valid     <= 1'b0;
      r_split         <= 1'b0;
      r_nr            <= '0;
      r_first_addr    <= '0;
      r_any_err       <= 1'b0;
      r_err_overflow  <= 1'b0;
      r_err_underflow <= 1'b0;
    end else begin
      r_trk_valid  <= rvfi_valid;
      r_split      <= (w_take == 2);
      r_nr         <= w_pop_cnt;
      r_first_addr <= (w_take != 0) ? w_head_addr : '0;
      r_any_err    <= (w_take != 0) && w_pop_err;
      if (w_ovf)                   r_err_overflow  <= 1'b1;
      if (w_cmpl_unf || w_ret_unf) r_err_underflow <= 1'b1;
    end
  end

  assign trk_valid          = r_trk_valid;
  assign is_split_datatrans = r_split;
  assign nr_obi_trans       = r_nr;
  assign first_addr         = r_first_addr;
  assign any_err            = r_any_err;
  assign err_overflow       = r_err_overflow;
  assign err_underflow      = r_err_underflow;

endmodule

// File: tb/tb_uvmt_cv32e40x_rvfi_obi_data_tracker.sv
// Bench for the RVFI/OBI data tracker: directed scenarios then random traffic,
// checked cycle by cycle against a queue-based transaction model.
module tb_uvmt_cv32e40x_rvfi_obi_data_tracker;

  localparam int unsigned NMEM  = 13;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = $clog2(NMEM + 1);

  logic              clk = 1'b0;
  logic              rst_ni = 1'b1;
  logic              data_req, data_gnt, data_we, data_rvalid, data_err;
  logic [31:0]       data_addr;
  logic              rvfi_valid, rvfi_trap_exception;
  logic [NMEM*4-1:0] rvfi_mem_rmask, rvfi_mem_wmask;
  logic              trk_valid, is_split_datatrans, any_err, err_overflow, err_underflow;
  logic [CW-1:0]     nr_obi_trans;
  logic [31:0]       first_addr;

  uvmt_cv32e40x_rvfi_obi_data_tracker #(.NMEM(NMEM), .DEPTH(DEPTH)) dut (
    .clk_i               (clk),
    .rst_ni              (rst_ni),
    .data_req            (data_req),
    .data_gnt            (data_gnt),
    .data_addr           (data_addr),
    .data_we             (data_we),
    .data_rvalid         (data_rvalid),
    .data_err            (data_err),
    .rvfi_valid          (rvfi_valid),
    .rvfi_trap_exception (rvfi_trap_exception),
    .rvfi_mem_rmask      (rvfi_mem_rmask),
    .rvfi_mem_wmask      (rvfi_mem_wmask),
    .trk_valid           (trk_valid),
    .is_split_datatrans  (is_split_datatrans),
    .nr_obi_trans        (nr_obi_trans),
    .first_addr          (first_addr),
    .any_err             (any_err),
    .err_overflow        (err_overflow),
    .err_underflow       (err_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    bit          done;
    bit          err;
  } ment_t;

  ment_t       q[$];
  bit          m_ovf, m_unf;
  bit          e_trk, e_split, e_err;
  int unsigned e_nr;
  logic [31:0] e_first;
  int          n_pass = 0;
  int          n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".trk_valid"},  32'(trk_valid),          32'(e_trk));
    check({tag, ".nr"},         32'(nr_obi_trans),       e_nr);
    check({tag, ".split"},      32'(is_split_datatrans), 32'(e_split));
    check({tag, ".first_addr"}, first_addr,              e_first);
    check({tag, ".any_err"},    32'(any_err),            32'(e_err));
    check({tag, ".overflow"},   32'(err_overflow),       32'(m_ovf));
    check({tag, ".underflow"},  32'(err_underflow),      32'(m_unf));
  endtask

  function automatic int unsigned groups(input logic [NMEM*4-1:0] m);
    int unsigned n = 0;
    for (int unsigned i = 0; i < NMEM; i++)
      if (((m >> (4 * i)) & 'hF) != 0) n++;
    return n;
  endfunction

  function automatic int unsigned done_prefix();
    int unsigned a = 0;
    while (a < q.size() && q[a].done) a++;
    return a;
  endfunction

  // Bus responses are in order, retirement consumes completed entries oldest first
  task automatic model_step();
    int unsigned n, avail, take;
    bit found;
    if (data_rvalid) begin
      found = 0;
      foreach (q[i]) if (!found && !q[i].done) begin
        q[i].done = 1; q[i].err = data_err; found = 1;
      end
      if (!found) m_unf = 1;
    end
    take = 0; e_first = 0; e_err = 0;
    if (rvfi_valid) begin
      n     = groups(rvfi_mem_rmask | rvfi_mem_wmask);
      avail = done_prefix();
      take  = (n < avail) ? n : avail;
      if (!rvfi_trap_exception && n > avail) m_unf = 1;
      if (take > 0) e_first = q[0].addr;
      for (int unsigned i = 0; i < take; i++) begin
        e_err = e_err | q[0].err;
        void'(q.pop_front());
      end
    end
    e_trk = rvfi_valid; e_nr = take; e_split = (take == 2);
    if (data_req && data_gnt) begin
      if (q.size() < DEPTH) q.push_back('{addr: data_addr, done: 0, err: 0});
      else m_ovf = 1;
    end
  endtask

  task automatic idle();
    data_req = 0; data_gnt = 0; data_addr = '0; data_we = 0;
    data_rvalid = 0; data_err = 0;
    rvfi_valid = 0; rvfi_trap_exception = 0;
    rvfi_mem_rmask = '0; rvfi_mem_wmask = '0;
  endtask

  task automatic cyc(input string tag);
    model_step();
    @(negedge clk);
    check_all(tag);
    idle();
  endtask

  task automatic grant(input logic [31:0] a, input logic we);
    data_req = 1; data_gnt = 1; data_addr = a; data_we = we;
  endtask

  // Called at a falling clock edge; holds reset across one rising edge
  task automatic do_reset(input string tag);
    idle();
    rst_ni = 0;
    #1;
    q.delete(); m_ovf = 0; m_unf = 0;
    e_trk = 0; e_split = 0; e_err = 0; e_nr = 0; e_first = 0;
    check_all({tag, ".async"});
    @(negedge clk);
    check_all({tag, ".hold"});
    rst_ni = 1;
  endtask

  initial begin
    int unsigned k, pre, outst;
    logic [NMEM*4-1:0] m;
    idle();
    #1;
    do_reset("reset");

    grant(32'h1000, 0);                cyc("lw_gnt");
    data_rvalid = 1;                   cyc("lw_rvalid");
    rvfi_valid = 1; rvfi_mem_rmask = 'hF; cyc("lw_ret");
    check("lw.nr_const", 32'(nr_obi_trans), 1);
    check("lw.addr_const", first_addr, 32'h1000);

    grant(32'h1000, 0);                cyc("mis_g0");
    grant(32'h1004, 0); data_rvalid = 1; cyc("mis_g1");
    data_rvalid = 1;                   cyc("mis_rv1");
    rvfi_valid = 1; rvfi_mem_rmask = 'h3C; cyc("mis_ret");
    check("mis.split_const", 32'(is_split_datatrans), 1);

    for (int unsigned i = 0; i < 5; i++) begin
      grant(32'h2000 + 4 * i, 1); cyc("push_g");
    end
    for (int unsigned i = 0; i < 5; i++) begin
      data_rvalid = 1; cyc("push_rv");
    end
    rvfi_valid = 1; rvfi_mem_wmask = 'hFFFFF; cyc("push_ret");
    check("push.nr_const", 32'(nr_obi_trans), 5);

    grant(32'h3000, 0);                cyc("err_g");
    data_rvalid = 1; data_err = 1;     cyc("err_rv");
    rvfi_valid = 1; rvfi_trap_exception = 1; rvfi_mem_rmask = 'hF; cyc("err_ret");
    check("err.any_const", 32'(any_err), 1);
    check("err.unf_const", 32'(err_underflow), 0);

    rvfi_valid = 1; rvfi_trap_exception = 1; rvfi_mem_rmask = 'hF; cyc("exc_early");
    rvfi_valid = 1;                    cyc("n0_ret");

    grant(32'h4000, 0);                cyc("same_g");
    data_rvalid = 1; rvfi_valid = 1; rvfi_mem_rmask = 'hF; cyc("same_cyc");
    check("same.nr_const", 32'(nr_obi_trans), 1);

    rvfi_valid = 1; rvfi_mem_rmask = 'hF; cyc("unf_ret");
    cyc("unf_sticky");
    check("unf.sticky_const", 32'(err_underflow), 1);

    for (int unsigned i = 0; i <= DEPTH; i++) begin
      grant(32'h5000 + 4 * i, 0); cyc("ovf_g");
    end
    check("ovf.const", 32'(err_overflow), 1);
    do_reset("mid_reset");

    grant(32'h6000, 0);                cyc("post_rst_g");
    data_rvalid = 1;                   cyc("post_rst_rv");
    rvfi_valid = 1; rvfi_mem_rmask = 'hF; cyc("post_rst_ret");

    for (int unsigned c = 0; c < 3000; c++) begin
      outst = 0;
      foreach (q[i]) if (!q[i].done) outst++;
      pre = done_prefix();
      if ($urandom_range(0, 99) < 35) begin
        data_req = 1; data_gnt = ($urandom_range(0, 3) != 0);
        data_addr = $urandom & 32'hFFFF_FFFC; data_we = $urandom_range(0, 1);
      end
      if ((outst > 0 && $urandom_range(0, 99) < 50) || $urandom_range(0, 299) == 0) begin
        data_rvalid = 1; data_err = ($urandom_range(0, 7) == 0);
      end
      if ($urandom_range(0, 99) < 30) begin
        rvfi_valid = 1;
        rvfi_trap_exception = ($urandom_range(0, 9) == 0);
        k = $urandom_range(0, (pre + 1 < NMEM) ? pre + 1 : NMEM);
        for (int unsigned g = 0; g < k; g++) begin
          m = NMEM * 4'(1'b0) | (NMEM*4)'($urandom_range(1, 15)) << (4 * g);
          if ($urandom_range(0, 1) == 1) rvfi_mem_rmask = rvfi_mem_rmask | m;
          else                           rvfi_mem_wmask = rvfi_mem_wmask | m;
        end
      end
      cyc("rand");
      if (c % 600 == 599) do_reset("rand_reset");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
